// File: rtl/cr_kme_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cr_kme_fifo_pkg
//  Purpose  : Width helpers shared by the parametrised KME FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package cr_kme_fifo_pkg;

    function automatic int fifo_ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr_kme_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : cr_kme_fifo_mem
//  Purpose  : Register array, one synchronous write port, one async read port.
//  Revision : 1.0 - initial release
// ============================================================================
module cr_kme_fifo_mem #(
    parameter int DATA_WIDTH = 263,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [PTR_WIDTH-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [PTR_WIDTH-1:0]  i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    // Payload storage carries no reset; validity is tracked by the occupancy count.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/cr_kme_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : cr_kme_fifo_param
//  Purpose  : Parametrised fall-through FIFO with early stall, clear and
//             occupancy / high-water reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module cr_kme_fifo_param
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 263,
    parameter int DEPTH           = 4,
    parameter int STALL_THRESHOLD = 0,
    parameter int CNT_WIDTH       = fifo_cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_in,
    input  logic                  fifo_in_valid,
    input  logic                  fifo_out_ack,
    input  logic                  fifo_in_stall_override,
    input  logic                  fifo_clear,
    output logic                  fifo_in_stall,
    output logic [DATA_WIDTH-1:0] fifo_out,
    output logic                  fifo_out_valid,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
    output logic [CNT_WIDTH-1:0]  used_slots,
    output logic [CNT_WIDTH-1:0]  free_slots,
    output logic [CNT_WIDTH-1:0]  high_water
);

    localparam int                   c_PTR_W     = fifo_ptr_width(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_STALL_TH  = CNT_WIDTH'(STALL_THRESHOLD);

    logic [c_PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_WIDTH-1:0]  r_used_q,   w_used_d;
    logic [CNT_WIDTH-1:0]  r_free_q,   w_free_d;
    logic [CNT_WIDTH-1:0]  r_high_q,   w_high_d;
    logic                  r_ovf_q,    w_ovf_d;
    logic                  r_unf_q,    w_unf_d;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Explicit wrap so non-power-of-two depths cycle correctly.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign fifo_out_valid = (r_used_q != '0);
    assign w_pop          = fifo_out_valid & fifo_out_ack;
    assign w_push         = fifo_in_valid & ((r_used_q < c_DEPTH_CNT) | w_pop);
    assign w_wr_en        = w_push & ~fifo_clear & ~rst;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_used_d   = r_used_q;
        w_free_d   = r_free_q;
        w_high_d   = r_high_q;
        w_ovf_d    = 1'b0;
        w_unf_d    = 1'b0;
        if (fifo_clear) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_used_d   = '0;
            w_free_d   = c_DEPTH_CNT;
            w_high_d   = '0;
        end else begin
            if (w_push) w_wr_ptr_d = ptr_inc(r_wr_ptr_q);
            if (w_pop)  w_rd_ptr_d = ptr_inc(r_rd_ptr_q);
            if (w_push && !w_pop) begin
                w_used_d = r_used_q + CNT_WIDTH'(1);
                w_free_d = r_free_q - CNT_WIDTH'(1);
            end else if (w_pop && !w_push) begin
                w_used_d = r_used_q - CNT_WIDTH'(1);
                w_free_d = r_free_q + CNT_WIDTH'(1);
            end
            if (w_used_d > r_high_q) w_high_d = w_used_d;
            w_ovf_d = fifo_in_valid & ~w_push;
            w_unf_d = fifo_out_ack & ~fifo_out_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_used_q   <= '0;
            r_free_q   <= c_DEPTH_CNT;
            r_high_q   <= '0;
            r_ovf_q    <= 1'b0;
            r_unf_q    <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_used_q   <= w_used_d;
            r_free_q   <= w_free_d;
            r_high_q   <= w_high_d;
            r_ovf_q    <= w_ovf_d;
            r_unf_q    <= w_unf_d;
        end
    end

    cr_kme_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (c_PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr_q),
        .i_wr_data (fifo_in),
        .i_rd_addr (r_rd_ptr_q),
        .o_rd_data (w_rd_data)
    );

    // Zero the output while empty so stale array contents never leak after reset.
    assign fifo_out       = fifo_out_valid ? w_rd_data : '0;
    assign fifo_in_stall  = (r_free_q <= c_STALL_TH) | fifo_in_stall_override;
    assign fifo_overflow  = r_ovf_q;
    assign fifo_underflow = r_unf_q;
    assign used_slots     = r_used_q;
    assign free_slots     = r_free_q;
    assign high_water     = r_high_q;

endmodule
`default_nettype wire

// File: tb/tb_cr_kme_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cr_kme_fifo_param
//  Purpose  : Scoreboard bench for cr_kme_fifo_param (three configurations).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cr_kme_fifo_param;

    localparam int c_DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [c_DW-1:0] din   [3];
    logic            vld   [3];
    logic            ack   [3];
    logic            ovr   [3];
    logic            clr   [3];
    logic            stall [3];
    logic [c_DW-1:0] dout  [3];
    logic            ovalid[3];
    logic            ovf   [3];
    logic            unf   [3];
    logic [2:0]      used  [3];
    logic [2:0]      free  [3];
    logic [2:0]      hw    [3];

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [c_DW-1:0] exp_q[$];
    logic [c_DW-1:0] mon_exp;

    always #5 clk = ~clk;

    // k=0: DEPTH 4 / TH 0, k=1: DEPTH 5 / TH 0, k=2: DEPTH 4 / TH 2
    cr_kme_fifo_param #(.DATA_WIDTH(c_DW), .DEPTH(4), .STALL_THRESHOLD(0)) u_a (
        .clk(clk), .rst(rst), .fifo_in(din[0]), .fifo_in_valid(vld[0]),
        .fifo_out_ack(ack[0]), .fifo_in_stall_override(ovr[0]), .fifo_clear(clr[0]),
        .fifo_in_stall(stall[0]), .fifo_out(dout[0]), .fifo_out_valid(ovalid[0]),
        .fifo_overflow(ovf[0]), .fifo_underflow(unf[0]), .used_slots(used[0]),
        .free_slots(free[0]), .high_water(hw[0]));

    cr_kme_fifo_param #(.DATA_WIDTH(c_DW), .DEPTH(5), .STALL_THRESHOLD(0)) u_b (
        .clk(clk), .rst(rst), .fifo_in(din[1]), .fifo_in_valid(vld[1]),
        .fifo_out_ack(ack[1]), .fifo_in_stall_override(ovr[1]), .fifo_clear(clr[1]),
        .fifo_in_stall(stall[1]), .fifo_out(dout[1]), .fifo_out_valid(ovalid[1]),
        .fifo_overflow(ovf[1]), .fifo_underflow(unf[1]), .used_slots(used[1]),
        .free_slots(free[1]), .high_water(hw[1]));

    cr_kme_fifo_param #(.DATA_WIDTH(c_DW), .DEPTH(4), .STALL_THRESHOLD(2)) u_c (
        .clk(clk), .rst(rst), .fifo_in(din[2]), .fifo_in_valid(vld[2]),
        .fifo_out_ack(ack[2]), .fifo_in_stall_override(ovr[2]), .fifo_clear(clr[2]),
        .fifo_in_stall(stall[2]), .fifo_out(dout[2]), .fifo_out_valid(ovalid[2]),
        .fifo_overflow(ovf[2]), .fifo_underflow(unf[2]), .used_slots(used[2]),
        .free_slots(free[2]), .high_water(hw[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle with the given inputs on instance k; others idle.
    task automatic step(input int k, input logic v, input logic [c_DW-1:0] d,
                        input logic a, input logic c, input logic acc);
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; ack[i] = 1'b0; clr[i] = 1'b0; din[i] = '0;
        end
        vld[k] = v; din[k] = d; ack[k] = a; clr[k] = c;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (c) exp_q.delete();
    endtask

    // Monitor: compare head data whenever a pop will occur at the next edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && ovalid[k] && ack[k]) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pop", {16'd0, dout[k]}, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("sb_data", {16'd0, dout[k]}, {16'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; vld[i] = 1'b0; ack[i] = 1'b0; ovr[i] = 1'b0; clr[i] = 1'b0;
        end
        ovr[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_used_a",  used[0], 0);
        chk("rst_free_a",  free[0], 4);
        chk("rst_free_b",  free[1], 5);
        chk("rst_hw_a",    hw[0], 0);
        chk("rst_valid_a", ovalid[0], 0);
        chk("rst_dout_a",  dout[0], 0);
        chk("rst_ovf_a",   ovf[0], 0);
        chk("rst_unf_a",   unf[0], 0);
        chk("rst_stall_ovr_a", stall[0], 1);
        chk("rst_stall_c", stall[2], 0);
        ovr[0] = 1'b0;
        rst = 1'b0;
        #1;
        chk("stall_after_ovr_a", stall[0], 0);

        // Fill to full, drop a fifth write, drain in order.
        step(0, 1, 16'hA0A0, 0, 0, 1);
        chk("first_write_valid", ovalid[0], 1);
        chk("first_write_dout", dout[0], 16'hA0A0);
        step(0, 1, 16'hB1B1, 0, 0, 1);
        step(0, 1, 16'hC2C2, 0, 0, 1);
        step(0, 1, 16'hD3D3, 0, 0, 1);
        chk("full_used", used[0], 4);
        chk("full_free", free[0], 0);
        chk("full_stall", stall[0], 1);
        step(0, 1, 16'hE4E4, 0, 0, 0);
        chk("ovf_pulse", ovf[0], 1);
        chk("ovf_used", used[0], 4);
        step(0, 0, 16'h0, 0, 0, 0);
        chk("ovf_cleared", ovf[0], 0);
        repeat (4) step(0, 0, 16'h0, 1, 0, 0);
        chk("drain_valid", ovalid[0], 0);
        chk("drain_used", used[0], 0);
        chk("drain_hw", hw[0], 4);
        chk("sb_drain1", exp_q.size(), 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(0, 1, 16'hF000 + 16'(i), 0, 0, 1);
        step(0, 1, 16'hF004, 1, 0, 1);
        chk("fullpp_ovf", ovf[0], 0);
        chk("fullpp_used", used[0], 4);
        repeat (4) step(0, 0, 16'h0, 1, 0, 0);
        chk("fullpp_empty", ovalid[0], 0);
        chk("sb_drain2", exp_q.size(), 0);

        // Underflow, then clear colliding with push and pop.
        step(0, 0, 16'h0, 1, 0, 0);
        chk("unf_pulse", unf[0], 1);
        chk("unf_used", used[0], 0);
        step(0, 0, 16'h0, 0, 0, 0);
        chk("unf_cleared", unf[0], 0);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h6000 + 16'(i), 0, 0, 1);
        chk("pre_clear_used", used[0], 3);
        step(0, 1, 16'h6BAD, 1, 1, 0);
        chk("clr_used", used[0], 0);
        chk("clr_free", free[0], 4);
        chk("clr_hw", hw[0], 0);
        chk("clr_valid", ovalid[0], 0);
        chk("clr_ovf", ovf[0], 0);
        chk("clr_unf", unf[0], 0);

        // Reset mid-stream, then first write after reset.
        for (int i = 0; i < 3; i++) step(0, 1, 16'h7000 + 16'(i), 0, 0, 1);
        rst = 1'b1;
        step(0, 1, 16'h7BAD, 1, 0, 0);
        exp_q.delete();
        rst = 1'b0;
        chk("mrst_used", used[0], 0);
        chk("mrst_free", free[0], 4);
        chk("mrst_hw", hw[0], 0);
        chk("mrst_valid", ovalid[0], 0);
        chk("mrst_dout", dout[0], 0);
        chk("mrst_ovf", ovf[0], 0);
        chk("mrst_unf", unf[0], 0);
        step(0, 1, 16'h7777, 0, 0, 1);
        chk("post_rst_valid", ovalid[0], 1);
        chk("post_rst_dout", dout[0], 16'h7777);
        step(0, 0, 16'h0, 1, 0, 0);
        chk("sb_drain3", exp_q.size(), 0);

        // DEPTH 5: streaming write+ack across two pointer wraps.
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 16'h5000 + 16'(i), (i != 0), 0, 1);
            if (i == 6 || i == 11) chk("d5_used_steady", used[1], 1);
        end
        chk("d5_hw", hw[1], 1);
        step(1, 0, 16'h0, 1, 0, 0);
        chk("d5_used_end", used[1], 0);
        chk("d5_ovf", ovf[1], 0);
        chk("sb_drain4", exp_q.size(), 0);

        // Early stall threshold 2 on DEPTH 4.
        chk("th_stall_0", stall[2], 0);
        step(2, 1, 16'h2001, 0, 0, 1);
        chk("th_stall_1", stall[2], 0);
        step(2, 1, 16'h2002, 0, 0, 1);
        chk("th_stall_2", stall[2], 1);
        step(2, 1, 16'h2003, 0, 0, 1);
        chk("th_stall_3", stall[2], 1);
        step(2, 1, 16'h2004, 0, 0, 1);
        chk("th_stall_4", stall[2], 1);
        chk("th_used_4", used[2], 4);
        repeat (4) step(2, 0, 16'h0, 1, 0, 0);
        chk("th_empty_stall", stall[2], 0);
        ovr[2] = 1'b1;
        #1;
        chk("ovr_stall", stall[2], 1);
        step(2, 1, 16'h2ACC, 0, 0, 1);
        chk("ovr_write_used", used[2], 1);
        step(2, 0, 16'h0, 1, 0, 0);
        ovr[2] = 1'b0;
        step(2, 0, 16'h0, 0, 0, 0);
        chk("sb_drain5", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
